vga_timing_gen: RTL and testbench
=================================

Name: vga_timing_gen

Overview:
Generates 640x480@60 Hz raster timing from the 25 MHz pixel clock. Produces pixel coordinates (DrawX, DrawY) and the active-video flag (blank) consumed by every tile/sprite mapper. Also produces the hs/vs syncs to the monitor, delayed to line up with the mappers' two-cycle colour pipeline (ROM read plus output register). Frame and line strobes drive animation logic.

Parameters:
H_VISIBLE, 640, visible pixels per line
H_FP, 16, horizontal front porch (clocks)
H_SYNC, 96, hsync pulse width (clocks)
H_BP, 48, horizontal back porch (clocks)
V_VISIBLE, 480, visible lines per frame
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vsync pulse width (lines)
V_BP, 33, vertical back porch (lines)
SYNC_DELAY, 2, register stages applied to hs/vs; 0 means combinational from the counters

Ports:
vga_clk  input  1  pixel clock; all state on rising edge
reset_n  input  1  asynchronous active-low reset
DrawX  output  10  horizontal counter hc, range 0..H_TOTAL-1
DrawY  output  10  vertical counter vc, range 0..V_TOTAL-1
blank  output  1  1 = visible pixel (hc<H_VISIBLE and vc<V_VISIBLE); 0 otherwise
hs  output  1  horizontal sync, active low, delayed SYNC_DELAY clocks
vs  output  1  vertical sync, active low, delayed SYNC_DELAY clocks
line_start  output  1  1-clock pulse when hc==0
frame_start  output  1  1-clock pulse when hc==0 and vc==0
frame_count  output  8  frames completed since reset; wraps 255->0

Behaviour:
- H_TOTAL = H_VISIBLE+H_FP+H_SYNC+H_BP (800). V_TOTAL likewise (525). Both totals must be <=1024; elaboration fails otherwise.
- Reset (reset_n low, asynchronous, any cycle): hc=0, vc=0, frame_count=0. All hs/vs delay stages=1 (inactive). blank, line_start and frame_start are forced to 0 while reset_n is low.
- First rising edge after reset_n rises: hc goes 0->1. From release until that edge, outputs decode (0,0): blank=1, line_start=1, frame_start=1.
- Counting each clock:
  - hc increments.
  - At hc==H_TOTAL-1, hc wraps to 0 and vc increments.
  - At vc==V_TOTAL-1 with hc==H_TOTAL-1, vc wraps to 0 and frame_count increments, mod 256.
  - No enable input; counters never stall.
- DrawX/DrawY are the counter registers directly (no latency).
- blank, line_start and frame_start are combinational decodes of the current hc/vc, so they align with DrawX/DrawY in the same cycle.
- Raw hsync is low for hc in [H_VISIBLE+H_FP, H_VISIBLE+H_FP+H_SYNC-1] = [656,751].
- Raw vsync is low for vc in [V_VISIBLE+V_FP, V_VISIBLE+V_FP+V_SYNC-1] = [490,491], for the whole line.
- hs/vs are raw hsync/vsync passed through a SYNC_DELAY-deep shift register. With default 2, hs falls at the clock edge two cycles after hc reaches 656.
- frame_count changes on the same edge where vc wraps to 0, so it is already updated when frame_start is seen high.
- Reset mid-frame: counters return to 0 immediately and sync pipes reload to 1. No partial-pulse or glitch requirement beyond that.

Test Plan:
- Reset, release, run 800 clocks: DrawX sequences 0..799 then 0, DrawY goes 0->1 on wrap. line_start high exactly at DrawX=0 on both lines.
- Sample blank over a full frame: high count = 640*480 = 307200 of 420000 clocks. blank=0 at (640,0) and (0,480); blank=1 at (639,479).
- SYNC_DELAY=2: hs falls two clocks after DrawX=656 and rises two clocks after DrawX=752. Low width is 96 clocks, repeating every 800.
- vs low from (DrawX=0, DrawY=490)+2 clocks to (DrawX=0, DrawY=492)+2 clocks, i.e. 1600 clocks. Period is 420000 clocks.
- Run 257 frames: frame_start pulses 257 times, each at (0,0); frame_count reads 1 at the end (wrapped 255->0).
- Assert reset_n at DrawX=700, DrawY=300 mid-clock: DrawX/DrawY=0, hs=vs=1 and blank=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/vga_timing_gen.sv
// 640x480@60 Hz raster timing: pixel/line counters, active-video decode,
// and hs/vs syncs delayed to match the downstream colour pipeline.
module vga_timing_gen #(
    parameter int H_VISIBLE  = 640,
    parameter int H_FP       = 16,
    parameter int H_SYNC     = 96,
    parameter int H_BP       = 48,
    parameter int V_VISIBLE  = 480,
    parameter int V_FP       = 10,
    parameter int V_SYNC     = 2,
    parameter int V_BP       = 33,
    parameter int SYNC_DELAY = 2
) (
    input  logic       vga_clk,
    input  logic       reset_n,
    output logic [9:0] DrawX,
    output logic [9:0] DrawY,
    output logic       blank,
    output logic       hs,
    output logic       vs,
    output logic       line_start,
    output logic       frame_start,
    output logic [7:0] frame_count
);

    localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;

    if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_total_check
        $error("vga_timing_gen: line or frame total exceeds 10-bit counter range");
    end

    localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS    = 10'(H_VISIBLE);
    localparam logic [9:0] V_VIS    = 10'(V_VISIBLE);
    localparam logic [9:0] HS_START = 10'(H_VISIBLE + H_FP);
    localparam logic [9:0] HS_END   = 10'(H_VISIBLE + H_FP + H_SYNC - 1);
    localparam logic [9:0] VS_START = 10'(V_VISIBLE + V_FP);
    localparam logic [9:0] VS_END   = 10'(V_VISIBLE + V_FP + V_SYNC - 1);

    logic [9:0] hc;
    logic [9:0] vc;
    logic       hs_raw;
    logic       vs_raw;

    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            hc          <= '0;
            vc          <= '0;
            frame_count <= '0;
        end else if (hc == H_LAST) begin
            hc <= '0;
            if (vc == V_LAST) begin
                vc          <= '0;
                frame_count <= frame_count + 8'd1;
            end else begin
                vc <= vc + 10'd1;
            end
        end else begin
            hc <= hc + 10'd1;
        end
    end

    assign DrawX = hc;
    assign DrawY = vc;

    // Decodes are gated by reset so nothing downstream sees a "visible" pixel mid-reset.
    always_comb begin
        blank       = reset_n && (hc < H_VIS) && (vc < V_VIS);
        line_start  = reset_n && (hc == '0);
        frame_start = reset_n && (hc == '0) && (vc == '0);
        hs_raw      = !((hc >= HS_START) && (hc <= HS_END));
        vs_raw      = !((vc >= VS_START) && (vc <= VS_END));
    end

    if (SYNC_DELAY == 0) begin : g_sync_comb
        assign hs = hs_raw;
        assign vs = vs_raw;
    end else begin : g_sync_pipe
        logic [SYNC_DELAY-1:0] hs_pipe;
        logic [SYNC_DELAY-1:0] vs_pipe;

        // Shift toward the MSB; the cast drops the oldest stage.
        always_ff @(posedge vga_clk or negedge reset_n) begin
            if (!reset_n) begin
                hs_pipe <= '1;
                vs_pipe <= '1;
            end else begin
                hs_pipe <= SYNC_DELAY'({hs_pipe, hs_raw});
                vs_pipe <= SYNC_DELAY'({vs_pipe, vs_raw});
            end
        end

        assign hs = hs_pipe[SYNC_DELAY-1];
        assign vs = vs_pipe[SYNC_DELAY-1];
    end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen: full-size timing on one instance,
// shrunk rasters (delayed and combinational syncs) for frame-level behaviour.
module tb_vga_timing_gen;

    logic vga_clk = 1'b0;
    logic rst0    = 1'b0;
    logic rst1    = 1'b0;

    always #5 vga_clk = ~vga_clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Full 640x480 instance
    logic [9:0] d0_x, d0_y;
    logic       d0_blank, d0_hs, d0_vs, d0_ls, d0_fs;
    logic [7:0] d0_fc;

    vga_timing_gen u_d0 (
        .vga_clk(vga_clk), .reset_n(rst0), .DrawX(d0_x), .DrawY(d0_y),
        .blank(d0_blank), .hs(d0_hs), .vs(d0_vs), .line_start(d0_ls),
        .frame_start(d0_fs), .frame_count(d0_fc)
    );

    // Small raster: 8 visible, fp 2, sync 3, bp 2 => 15; 6 lines, fp 1, sync 2, bp 1 => 10
    logic [9:0] s1_x, s1_y, s2_x, s2_y;
    logic       s1_blank, s1_hs, s1_vs, s1_ls, s1_fs;
    logic       s2_blank, s2_hs, s2_vs, s2_ls, s2_fs;
    logic [7:0] s1_fc, s2_fc;

    vga_timing_gen #(
        .H_VISIBLE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
        .V_VISIBLE(6), .V_FP(1), .V_SYNC(2), .V_BP(1), .SYNC_DELAY(2)
    ) u_s1 (
        .vga_clk(vga_clk), .reset_n(rst1), .DrawX(s1_x), .DrawY(s1_y),
        .blank(s1_blank), .hs(s1_hs), .vs(s1_vs), .line_start(s1_ls),
        .frame_start(s1_fs), .frame_count(s1_fc)
    );

    vga_timing_gen #(
        .H_VISIBLE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
        .V_VISIBLE(6), .V_FP(1), .V_SYNC(2), .V_BP(1), .SYNC_DELAY(0)
    ) u_s2 (
        .vga_clk(vga_clk), .reset_n(rst1), .DrawX(s2_x), .DrawY(s2_y),
        .blank(s2_blank), .hs(s2_hs), .vs(s2_vs), .line_start(s2_ls),
        .frame_start(s2_fs), .frame_count(s2_fc)
    );

    task automatic test_reset();
        rst0 = 1'b0;
        rst1 = 1'b0;
        repeat (3) @(posedge vga_clk);
        @(negedge vga_clk);
        n_checks++; if ({d0_x, d0_y} !== 20'd0) begin n_fail++; $display("FAIL reset_d0_xy got %0d,%0d want 0,0", d0_x, d0_y); end
        n_checks++; if ({d0_blank, d0_ls, d0_fs} !== 3'b000) begin n_fail++; $display("FAIL reset_d0_decodes got %b want 000", {d0_blank, d0_ls, d0_fs}); end
        n_checks++; if ({d0_hs, d0_vs} !== 2'b11) begin n_fail++; $display("FAIL reset_d0_sync got %b want 11", {d0_hs, d0_vs}); end
        n_checks++; if (d0_fc !== 8'd0) begin n_fail++; $display("FAIL reset_d0_fc got %0d want 0", d0_fc); end
        n_checks++; if ({s1_blank, s1_ls, s1_fs, s1_hs, s1_vs} !== 5'b00011) begin n_fail++; $display("FAIL reset_s1 got %b want 00011", {s1_blank, s1_ls, s1_fs, s1_hs, s1_vs}); end
        n_checks++; if ({s2_blank, s2_ls, s2_fs, s2_hs, s2_vs} !== 5'b00011) begin n_fail++; $display("FAIL reset_s2 got %b want 00011", {s2_blank, s2_ls, s2_fs, s2_hs, s2_vs}); end
        rst0 = 1'b1;
        rst1 = 1'b1;
        #1;
        n_checks++; if ({d0_blank, d0_ls, d0_fs} !== 3'b111) begin n_fail++; $display("FAIL release_d0_decodes got %b want 111", {d0_blank, d0_ls, d0_fs}); end
        n_checks++; if ({d0_x, d0_y} !== 20'd0) begin n_fail++; $display("FAIL release_d0_xy got %0d,%0d want 0,0", d0_x, d0_y); end
    endtask

    // Continues straight from release: sample k is taken after k rising edges.
    task automatic test_line_count();
        int x, y;
        for (int k = 0; k <= 800; k++) begin
            x = k % 800;
            y = (k >= 800) ? 1 : 0;
            n_checks++; if (d0_x !== 10'(x) || d0_y !== 10'(y)) begin n_fail++; $display("FAIL line_xy k=%0d got %0d,%0d want %0d,%0d", k, d0_x, d0_y, x, y); end
            n_checks++; if (d0_ls !== (x == 0)) begin n_fail++; $display("FAIL line_start k=%0d got %b want %b", k, d0_ls, (x == 0)); end
            n_checks++; if (d0_blank !== (x < 640)) begin n_fail++; $display("FAIL line_blank k=%0d got %b want %b", k, d0_blank, (x < 640)); end
            n_checks++; if (d0_hs !== !(x >= 658 && x <= 753)) begin n_fail++; $display("FAIL line_hs k=%0d got %b want %b", k, d0_hs, !(x >= 658 && x <= 753)); end
            n_checks++; if (d0_fs !== (k == 0)) begin n_fail++; $display("FAIL line_frame_start k=%0d got %b want %b", k, d0_fs, (k == 0)); end
            @(negedge vga_clk);
        end
    endtask

    task automatic test_hsync();
        int i, lows, falls, rises, first_fall, second_fall;
        logic prev;
        for (i = 0; i < 1000 && d0_x !== 10'd0; i++) @(negedge vga_clk);
        n_checks++; if (d0_x !== 10'd0) begin n_fail++; $display("FAIL hsync_sync_wait got DrawX=%0d want 0", d0_x); end
        lows = 0; falls = 0; rises = 0; first_fall = -1; second_fall = -1;
        prev = d0_hs;
        for (int k = 0; k < 1600; k++) begin
            if (d0_hs === 1'b0) lows++;
            if (prev === 1'b1 && d0_hs === 1'b0) begin
                falls++;
                if (first_fall < 0) first_fall = k; else second_fall = k;
                n_checks++; if (d0_x !== 10'd658) begin n_fail++; $display("FAIL hs_fall_pos got DrawX=%0d want 658", d0_x); end
            end
            if (prev === 1'b0 && d0_hs === 1'b1) begin
                rises++;
                n_checks++; if (d0_x !== 10'd754) begin n_fail++; $display("FAIL hs_rise_pos got DrawX=%0d want 754", d0_x); end
            end
            prev = d0_hs;
            @(negedge vga_clk);
        end
        n_checks++; if (lows != 192) begin n_fail++; $display("FAIL hs_low_count got %0d want 192", lows); end
        n_checks++; if (falls != 2 || rises != 2) begin n_fail++; $display("FAIL hs_edge_count got falls=%0d rises=%0d want 2,2", falls, rises); end
        n_checks++; if (second_fall - first_fall != 800) begin n_fail++; $display("FAIL hs_period got %0d want 800", second_fall - first_fall); end
    endtask

    task automatic test_small_frame();
        int i, x, y, p, blanks, vlows, vfalls, fall0, fall1;
        logic prev_vs, e_vs;
        for (i = 0; i < 200 && s1_fs !== 1'b1; i++) @(negedge vga_clk);
        n_checks++; if (s1_fs !== 1'b1) begin n_fail++; $display("FAIL small_frame_wait got frame_start=%b want 1", s1_fs); end
        blanks = 0; vlows = 0; vfalls = 0; fall0 = -1; fall1 = -1;
        prev_vs = s1_vs;
        for (int k = 0; k < 300; k++) begin
            x = k % 15;
            y = (k / 15) % 10;
            p = y * 15 + x;
            e_vs = !(p >= 107 && p <= 136);
            n_checks++; if (s1_x !== 10'(x) || s1_y !== 10'(y)) begin n_fail++; $display("FAIL small_xy k=%0d got %0d,%0d want %0d,%0d", k, s1_x, s1_y, x, y); end
            n_checks++; if (s1_blank !== (x < 8 && y < 6)) begin n_fail++; $display("FAIL small_blank (%0d,%0d) got %b want %b", x, y, s1_blank, (x < 8 && y < 6)); end
            n_checks++; if (s1_fs !== (x == 0 && y == 0) || s1_ls !== (x == 0)) begin n_fail++; $display("FAIL small_strobes (%0d,%0d) got fs=%b ls=%b", x, y, s1_fs, s1_ls); end
            n_checks++; if (s1_hs !== !(x >= 12 && x <= 14)) begin n_fail++; $display("FAIL small_hs (%0d,%0d) got %b want %b", x, y, s1_hs, !(x >= 12 && x <= 14)); end
            n_checks++; if (s1_vs !== e_vs) begin n_fail++; $display("FAIL small_vs (%0d,%0d) got %b want %b", x, y, s1_vs, e_vs); end
            n_checks++; if (s2_hs !== !(x >= 10 && x <= 12)) begin n_fail++; $display("FAIL comb_hs (%0d,%0d) got %b want %b", x, y, s2_hs, !(x >= 10 && x <= 12)); end
            n_checks++; if (s2_vs !== !(y == 7 || y == 8)) begin n_fail++; $display("FAIL comb_vs (%0d,%0d) got %b want %b", x, y, s2_vs, !(y == 7 || y == 8)); end
            if (k < 150 && s1_blank === 1'b1) blanks++;
            if (k < 150 && s1_vs === 1'b0) vlows++;
            if (prev_vs === 1'b1 && s1_vs === 1'b0) begin
                vfalls++;
                if (fall0 < 0) fall0 = k; else fall1 = k;
            end
            prev_vs = s1_vs;
            @(negedge vga_clk);
        end
        n_checks++; if (blanks != 48) begin n_fail++; $display("FAIL small_blank_count got %0d want 48", blanks); end
        n_checks++; if (vlows != 30) begin n_fail++; $display("FAIL small_vs_low_count got %0d want 30", vlows); end
        n_checks++; if (vfalls != 2 || fall0 != 107 || fall1 - fall0 != 150) begin n_fail++; $display("FAIL small_vs_period got falls=%0d first=%0d period=%0d want 2,107,150", vfalls, fall0, fall1 - fall0); end
    endtask

    task automatic test_midframe_reset();
        int i;
        for (i = 0; i < 1000 && d0_x !== 10'd700; i++) @(negedge vga_clk);
        n_checks++; if (d0_x !== 10'd700 || d0_hs !== 1'b0) begin n_fail++; $display("FAIL midreset_setup got DrawX=%0d hs=%b want 700,0", d0_x, d0_hs); end
        #2;
        rst0 = 1'b0;
        rst1 = 1'b0;
        #1;
        n_checks++; if ({d0_x, d0_y} !== 20'd0) begin n_fail++; $display("FAIL midreset_d0_xy got %0d,%0d want 0,0", d0_x, d0_y); end
        n_checks++; if ({d0_hs, d0_vs, d0_blank, d0_ls, d0_fs} !== 5'b11000) begin n_fail++; $display("FAIL midreset_d0_out got %b want 11000", {d0_hs, d0_vs, d0_blank, d0_ls, d0_fs}); end
        n_checks++; if ({s1_x, s1_y} !== 20'd0 || s1_fc !== 8'd0) begin n_fail++; $display("FAIL midreset_s1_cnt got %0d,%0d fc=%0d want 0,0,0", s1_x, s1_y, s1_fc); end
        n_checks++; if ({s1_hs, s1_vs, s1_blank} !== 3'b110) begin n_fail++; $display("FAIL midreset_s1_out got %b want 110", {s1_hs, s1_vs, s1_blank}); end
        @(negedge vga_clk);
        n_checks++; if (d0_x !== 10'd0) begin n_fail++; $display("FAIL midreset_hold got DrawX=%0d want 0", d0_x); end
        rst0 = 1'b1;
        @(negedge vga_clk);
        n_checks++; if (d0_x !== 10'd1 || d0_y !== 10'd0) begin n_fail++; $display("FAIL midreset_restart got %0d,%0d want 1,0", d0_x, d0_y); end
    endtask

    task automatic test_frame_count();
        int pulses;
        rst1 = 1'b0;
        #1;
        n_checks++; if (s1_fc !== 8'd0) begin n_fail++; $display("FAIL fc_reset got %0d want 0", s1_fc); end
        @(negedge vga_clk);
        rst1 = 1'b1;
        pulses = 0;
        for (int k = 0; k <= 257 * 150; k++) begin
            if (s1_fs === 1'b1) begin
                if (k > 0) pulses++;
                n_checks++; if (s1_x !== 10'd0 || s1_y !== 10'd0 || (k % 150) != 0) begin n_fail++; $display("FAIL fs_position k=%0d got %0d,%0d want 0,0 on a frame boundary", k, s1_x, s1_y); end
                n_checks++; if (s1_fc !== 8'((k / 150) % 256)) begin n_fail++; $display("FAIL fc_at_fs k=%0d got %0d want %0d", k, s1_fc, (k / 150) % 256); end
            end
            if (k == 255 * 150) begin
                n_checks++; if (s1_fc !== 8'd255) begin n_fail++; $display("FAIL fc_255 got %0d want 255", s1_fc); end
            end
            if (k == 256 * 150) begin
                n_checks++; if (s1_fc !== 8'd0) begin n_fail++; $display("FAIL fc_wrap got %0d want 0", s1_fc); end
            end
            if (k == 256 * 150 - 1) begin
                n_checks++; if (s1_fc !== 8'd255) begin n_fail++; $display("FAIL fc_before_wrap got %0d want 255", s1_fc); end
            end
            if (k < 257 * 150) @(negedge vga_clk);
        end
        n_checks++; if (pulses != 257) begin n_fail++; $display("FAIL fs_pulse_count got %0d want 257", pulses); end
        n_checks++; if (s1_fc !== 8'd1) begin n_fail++; $display("FAIL fc_final got %0d want 1", s1_fc); end
    endtask

    initial begin
        test_reset();
        test_line_count();
        test_hsync();
        test_small_frame();
        test_midframe_reset();
        test_frame_count();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
